chest_pilot_avg: RTL and testbench

CHEST_PILOT_AVG -- requirements
Module: chest_pilot_avg

---
 rtl/chest_pilot_avg.sv | 144 ++++++++++++++
 tb/tb_chest_pilot_avg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/chest_pilot_avg.sv
// chest_pilot_avg: averages groups of N = 2^N_LOG2 de-rotated pilot LS estimates.
// It uses round-half-up and emits one registered result per group, with a
// rolling 2-bit write address for the downstream estimate buffer.
//
// Ports:
//   clk        - clock; all state updates on its rising edge
//   rst        - asynchronous active-high reset
//   en         - sample-accept enable (a sample is taken when in_valid & en)
//   clr        - synchronous discard of the partial group
//   in_valid   - qualifies in_r / in_i
//   in_r, in_i - signed real/imag estimates, WIDTH bits
//   out_valid  - one-cycle pulse qualifying avg_r / avg_i / out_addr
//   avg_r/avg_i- signed rounded group averages, held between pulses
//   out_addr   - estimate-buffer write address, advances after each pulse
module chest_pilot_avg #(
  parameter int unsigned WIDTH  = 17,
  parameter int unsigned N_LOG2 = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_r,
  input  logic signed [WIDTH-1:0] in_i,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] avg_r,
  output logic signed [WIDTH-1:0] avg_i,
  output logic [1:0]              out_addr
);

  localparam int unsigned AW = WIDTH + N_LOG2 + 1;
  localparam int unsigned N  = 1 << N_LOG2;
  localparam logic signed [AW-1:0]     RND      = AW'(N / 2);
  localparam logic        [N_LOG2-1:0] CNT_LAST = N_LOG2'(N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [N_LOG2-1:0]       r_cnt, w_cnt_nxt;
  logic signed [AW-1:0]    r_acc_r, r_acc_i, w_acc_r_nxt, w_acc_i_nxt;
  logic signed [AW-1:0]    w_in_r_ext, w_in_i_ext, w_sum_r, w_sum_i;
  logic signed [WIDTH-1:0] w_avg_r, w_avg_i;
  logic                    w_accept, w_last, w_out_valid_nxt;

  logic                    r_out_valid;
  logic signed [WIDTH-1:0] r_avg_r, r_avg_i;
  logic [1:0]              r_out_addr;

  // Sign-extended inputs and running sums including the current sample.
  assign w_accept   = in_valid & en;
  assign w_in_r_ext = AW'(in_r);
  assign w_in_i_ext = AW'(in_i);
  assign w_sum_r    = r_acc_r + w_in_r_ext;
  assign w_sum_i    = r_acc_i + w_in_i_ext;

  // Round half up, then arithmetic shift; the result always fits WIDTH bits.
  assign w_avg_r = WIDTH'((w_sum_r + RND) >>> N_LOG2);
  assign w_avg_i = WIDTH'((w_sum_i + RND) >>> N_LOG2);

  // Nth sample of a group; a coincident clr suppresses completion.
  assign w_last = w_accept && !clr && (r_state == ACC) && (r_cnt == CNT_LAST);

  // Group state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_acc_r <= '0;
      r_acc_i <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc_r <= w_acc_r_nxt;
      r_acc_i <= w_acc_i_nxt;
    end
  end

  // Next-state: clr restarts the group, with the coincident sample as its first.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_acc_r_nxt     = r_acc_r;
    w_acc_i_nxt     = r_acc_i;
    w_out_valid_nxt = 1'b0;
    if (clr) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_acc_r_nxt = '0;
      w_acc_i_nxt = '0;
      if (w_accept) begin
        w_state_nxt = ACC;
        w_cnt_nxt   = N_LOG2'(1);
        w_acc_r_nxt = w_in_r_ext;
        w_acc_i_nxt = w_in_i_ext;
      end
    end else if (w_accept) begin
      if (r_state == IDLE) begin
        w_state_nxt = ACC;
        w_cnt_nxt   = N_LOG2'(1);
        w_acc_r_nxt = w_in_r_ext;
        w_acc_i_nxt = w_in_i_ext;
      end else if (w_last) begin
        w_state_nxt     = IDLE;
        w_cnt_nxt       = '0;
        w_acc_r_nxt     = '0;
        w_acc_i_nxt     = '0;
        w_out_valid_nxt = 1'b1;
      end else begin
        w_cnt_nxt   = r_cnt + N_LOG2'(1);
        w_acc_r_nxt = w_sum_r;
        w_acc_i_nxt = w_sum_i;
      end
    end
  end

  // Output registers; address advances after each published result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_avg_r     <= '0;
      r_avg_i     <= '0;
      r_out_addr  <= '0;
    end else begin
      r_out_valid <= w_out_valid_nxt;
      if (w_out_valid_nxt) begin
        r_avg_r <= w_avg_r;
        r_avg_i <= w_avg_i;
      end
      if (r_out_valid) begin
        r_out_addr <= r_out_addr + 2'd1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign avg_r     = r_avg_r;
  assign avg_i     = r_avg_i;
  assign out_addr  = r_out_addr;

endmodule

// File: tb/tb_chest_pilot_avg.sv
// Directed bench for chest_pilot_avg (WIDTH=17, N=4) with hand-computed expectations.
module tb_chest_pilot_avg;

  localparam int unsigned WIDTH  = 17;
  localparam int unsigned N_LOG2 = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    en;
  logic                    clr;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_r;
  logic signed [WIDTH-1:0] in_i;
  logic                    out_valid;
  logic signed [WIDTH-1:0] avg_r;
  logic signed [WIDTH-1:0] avg_i;
  logic [1:0]              out_addr;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  chest_pilot_avg #(
    .WIDTH (WIDTH),
    .N_LOG2(N_LOG2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .in_valid (in_valid),
    .in_r     (in_r),
    .in_i     (in_i),
    .out_valid(out_valid),
    .avg_r    (avg_r),
    .avg_i    (avg_i),
    .out_addr (out_addr)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic v, input logic e, input logic c,
                      input int r, input int i);
    in_valid = v;
    en       = e;
    clr      = c;
    in_r     = WIDTH'(r);
    in_i     = WIDTH'(i);
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input int r, input int i);
    step(1'b1, 1'b1, 1'b0, r, i);
  endtask

  task automatic expect_none(input string tag);
    chk({tag, ".valid0"}, 32'(out_valid), 0);
  endtask

  task automatic expect_out(input string tag, input int r, input int i, input int a);
    chk({tag, ".valid1"}, 32'(out_valid), 1);
    chk({tag, ".avg_r"}, avg_r, r);
    chk({tag, ".avg_i"}, avg_i, i);
    chk({tag, ".addr"}, 32'(out_addr), a);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_r = '0; in_i = '0;
    #1;
    chk("reset.valid", 32'(out_valid), 0);
    chk("reset.avg_r", avg_r, 0);
    chk("reset.avg_i", avg_i, 0);
    chk("reset.addr", 32'(out_addr), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic group: (1000+2)>>2=250, (-1001+2)>>>2=-250
    smp(100, -100);  expect_none("basic1");
    smp(200, -200);  expect_none("basic2");
    smp(300, -300);  expect_none("basic3");
    smp(400, -401);  expect_out("basic", 250, -250, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    expect_none("basic.after");
    chk("basic.hold_r", avg_r, 250);
    chk("basic.addr_inc", 32'(out_addr), 1);
    // valid without en must be ignored
    step(1'b1, 1'b0, 1'b0, 5000, 5000);
    expect_none("en0");

    // Extremes without wrap
    smp(65535, -65536); expect_none("ext1");
    smp(65535, -65536); expect_none("ext2");
    smp(65535, -65536); expect_none("ext3");
    smp(65535, -65536); expect_out("ext", 65535, -65536, 1);

    // Rounding: real 1,1,0,0 -> 1; imag -1,-1,0,0 -> 0
    smp(1, -1); expect_none("rnd1a");
    smp(1, -1); expect_none("rnd1b");
    smp(0, 0);  expect_none("rnd1c");
    smp(0, 0);  expect_out("rnd1", 1, 0, 2);
    // -2,-2,-2,-1 -> -7+2=-5 >>> 2 = -2
    smp(-2, -2); expect_none("rnd2a");
    smp(-2, -2); expect_none("rnd2b");
    smp(-2, -2); expect_none("rnd2c");
    smp(-1, -1); expect_out("rnd2", -2, -2, 3);

    // Streaming: 5 back-to-back groups, addresses 0,1,2,3,0
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) begin
        smp(7, 7);
        if (k == 3) expect_out($sformatf("stream%0d", g), 7, 7, g % 4);
        else        expect_none($sformatf("stream%0d_%0d", g, k));
      end
    end

    // clr discards partial group of 50s; en gap is not counted
    smp(50, 50); expect_none("clr50a");
    smp(50, 50); expect_none("clr50b");
    step(1'b0, 1'b1, 1'b1, 0, 0);
    expect_none("clr");
    chk("clr.hold_r", avg_r, 7);
    chk("clr.hold_addr", 32'(out_addr), 1);
    smp(8, 8); expect_none("gap1");
    step(1'b1, 1'b0, 1'b0, 999, 999); expect_none("gap_ign");
    smp(8, 8); expect_none("gap2");
    smp(8, 8); expect_none("gap3");
    smp(8, 8); expect_out("gap", 8, 8, 1);

    // clr coinciding with the Nth sample: clr wins, sample starts new group
    smp(20, 20); expect_none("clrN1");
    smp(20, 20); expect_none("clrN2");
    smp(20, 20); expect_none("clrN3");
    step(1'b1, 1'b1, 1'b1, 4, 4); expect_none("clrN4");
    smp(4, 4); expect_none("clrN5");
    smp(4, 4); expect_none("clrN6");
    smp(4, 4); expect_out("clrN", 4, 4, 2);

    // Reset mid-group
    smp(9, 9); expect_none("rst9a");
    smp(9, 9); expect_none("rst9b");
    smp(9, 9); expect_none("rst9c");
    rst = 1'b1;
    #1;
    chk("rstmid.valid", 32'(out_valid), 0);
    chk("rstmid.avg_r", avg_r, 0);
    chk("rstmid.avg_i", avg_i, 0);
    chk("rstmid.addr", 32'(out_addr), 0);
    step(1'b1, 1'b1, 1'b0, 9, 9);
    expect_none("rsthold");
    chk("rsthold.avg_r", avg_r, 0);
    rst = 1'b0;
    smp(3, 3); expect_none("post1");
    smp(3, 3); expect_none("post2");
    smp(3, 3); expect_none("post3");
    smp(3, 3); expect_out("post", 3, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
